// File: rtl/proc_control_if.sv
// Instruction-sequencer bus: run/din from the instruction source, control
// strobes out to the register file, ALU and bus mux.
interface proc_control_if #(
    parameter int DATA_W = 16
);
    logic              run;
    logic [DATA_W-1:0] din;
    logic [7:0]        rin;
    logic [7:0]        rout;
    logic              ain;
    logic              gin;
    logic              sub;
    logic              gout;
    logic              dinout;
    logic              done;
    logic              busy;

    modport master (
        output run, din,
        input  rin, rout, ain, gin, sub, gout, dinout, done, busy
    );

    modport slave (
        input  run, din,
        output rin, rout, ain, gin, sub, gout, dinout, done, busy
    );
endinterface

// File: rtl/proc_control.sv
// Instruction-sequencing FSM: fetches a 9-bit instruction (III XXX YYY) in T0
// and drives register/ALU/bus strobes over T1..T3.
module proc_control #(
    parameter int DATA_W = 16
) (
    input  logic           clock,
    input  logic           resetn,
    proc_control_if.slave  bus
);
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [8:0] ir;

    logic [2:0] op;
    logic [7:0] sel_x;
    logic [7:0] sel_y;

    // Only din[8:0] carries the instruction; the upper bits belong to the datapath.
    logic unused_din_hi;
    assign unused_din_hi = ^bus.din[DATA_W-1:9];

    assign op    = ir[8:6];
    assign sel_x = 8'b1 << ir[5:3];
    assign sel_y = 8'b1 << ir[2:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == T0 && bus.run)
                ir <= bus.din[8:0];
        end
    end

    always_comb begin
        state_next = state;
        bus.rin    = '0;
        bus.rout   = '0;
        bus.ain    = 1'b0;
        bus.gin    = 1'b0;
        bus.sub    = 1'b0;
        bus.gout   = 1'b0;
        bus.dinout = 1'b0;
        bus.done   = 1'b0;
        bus.busy   = (state != T0);

        case (state)
            T0: begin
                if (bus.run)
                    state_next = T1;
            end
            T1: begin
                case (op)
                    3'b000: begin
                        bus.rout   = sel_y;
                        bus.rin    = sel_x;
                        bus.done   = 1'b1;
                        state_next = T0;
                    end
                    3'b001: begin
                        bus.dinout = 1'b1;
                        bus.rin    = sel_x;
                        bus.done   = 1'b1;
                        state_next = T0;
                    end
                    3'b010, 3'b011: begin
                        bus.rout   = sel_x;
                        bus.ain    = 1'b1;
                        state_next = T2;
                    end
                    default: begin
                        bus.done   = 1'b1;
                        state_next = T0;
                    end
                endcase
            end
            T2: begin
                // Only add/sub reach T2; IR[6] distinguishes them.
                bus.rout   = sel_y;
                bus.gin    = 1'b1;
                bus.sub    = ir[6];
                state_next = T3;
            end
            T3: begin
                bus.gout   = 1'b1;
                bus.rin    = sel_x;
                bus.done   = 1'b1;
                state_next = T0;
            end
            default: state_next = T0;
        endcase
    end
endmodule

// File: tb/tb_proc_control.sv
// Self-checking bench for proc_control: per-instruction expected strobe
// sequences checked every cycle, plus directed literal checks.
module tb_proc_control;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       sub;
        logic       gout;
        logic       dinout;
        logic       done;
        logic       busy;
    } out_t;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    proc_control_if #(.DATA_W(DATA_W)) pif ();

    proc_control #(.DATA_W(DATA_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (pif)
    );

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];

    function automatic out_t mk(logic [7:0] rin, logic [7:0] rout, logic ain, logic gin,
                                logic sub, logic gout, logic dinout, logic done, logic busy);
        out_t r;
        r.rin = rin;   r.rout = rout;     r.ain = ain;   r.gin = gin;  r.sub = sub;
        r.gout = gout; r.dinout = dinout; r.done = done; r.busy = busy;
        return r;
    endfunction

    // Strobe sequence for one instruction, one entry per cycle after the fetch edge.
    function automatic void expand(logic [8:0] instr);
        logic [7:0] x;
        logic [7:0] y;
        x = 8'(1) << instr[5:3];
        y = 8'(1) << instr[2:0];
        case (instr[8:6])
            3'd0: exp_q.push_back(mk(x, y, 0, 0, 0, 0, 0, 1, 1));
            3'd1: exp_q.push_back(mk(x, 8'h00, 0, 0, 0, 0, 1, 1, 1));
            3'd2, 3'd3: begin
                exp_q.push_back(mk(8'h00, x, 1, 0, 0, 0, 0, 0, 1));
                exp_q.push_back(mk(8'h00, y, 0, 1, instr[6], 0, 0, 0, 1));
                exp_q.push_back(mk(x, 8'h00, 0, 0, 0, 1, 0, 1, 1));
            end
            default: exp_q.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
        endcase
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn)
            exp_q.delete();
        else if (exp_q.size() == 0) begin
            if (pif.run)
                expand(pif.din[8:0]);
        end else
            void'(exp_q.pop_front());
    end

    function automatic out_t actual();
        return {pif.rin, pif.rout, pif.ain, pif.gin, pif.sub, pif.gout,
                pif.dinout, pif.done, pif.busy};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    task automatic lit(string name, out_t expv);
        check(name, 32'(actual()), 32'(expv));
    endtask

    task automatic compare_cycle();
        out_t a;
        out_t e;
        a = actual();
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("cycle", 32'(a), 32'(e));
        check("bus_drivers", 32'(($countones(a.rout) + 32'(a.gout) + 32'(a.dinout)) <= 1), 32'd1);
        check("rin_onehot", 32'($onehot0(a.rin)), 32'd1);
        check("ain_gin", 32'(a.ain & a.gin), 32'd0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn  = 1'b0;
        pif.run = 1'b1;
        pif.din = 16'h0049;
        fork
            forever begin
                @(negedge clock);
                compare_cycle();
            end
            begin
                repeat (3) step();
                lit("reset_idle", '0);
                resetn = 1'b1;
                step();
                lit("mvi_t1", mk(8'h02, 8'h00, 0, 0, 0, 0, 1, 1, 1));
                pif.run = 1'b0;
                step();
                lit("mvi_back_t0", '0);

                pif.din = 16'h002A; pif.run = 1'b1;
                step();
                pif.run = 1'b0;
                lit("mv_t1", mk(8'h20, 8'h04, 0, 0, 0, 0, 0, 1, 1));
                step();

                pif.din = 16'h0081; pif.run = 1'b1;
                step();
                pif.run = 1'b0;
                lit("add_t1", mk(8'h00, 8'h01, 1, 0, 0, 0, 0, 0, 1));
                step();
                lit("add_t2", mk(8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 1));
                step();
                lit("add_t3", mk(8'h01, 8'h00, 0, 0, 0, 1, 0, 1, 1));
                step();
                lit("add_idle", '0);

                pif.din = 16'h00DC; pif.run = 1'b1;
                step();
                lit("sub_t1", mk(8'h00, 8'h08, 1, 0, 0, 0, 0, 0, 1));
                step();
                lit("sub_t2", mk(8'h00, 8'h10, 0, 1, 1, 0, 0, 0, 1));
                step();
                lit("sub_t3", mk(8'h08, 8'h00, 0, 0, 0, 1, 0, 1, 1));
                step();
                lit("sub_gap_t0", '0);
                step();
                lit("sub_refetch", mk(8'h00, 8'h08, 1, 0, 0, 0, 0, 0, 1));
                pif.run = 1'b0;
                repeat (3) step();
                lit("sub_done_idle", '0);

                pif.din = 16'h0081; pif.run = 1'b1;
                step();
                pif.run = 1'b0;
                step();
                lit("rst_add_t2", mk(8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 1));
                #2 resetn = 1'b0;
                #1 lit("reset_async", '0);
                repeat (2) step();
                resetn = 1'b1;
                repeat (3) begin
                    step();
                    lit("post_reset_idle", '0);
                end

                pif.din = 16'h01FF; pif.run = 1'b1;
                step();
                pif.run = 1'b0;
                lit("undef_t1", mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
                step();

                pif.din = 16'h001B; pif.run = 1'b1;
                step();
                pif.run = 1'b0;
                lit("mv_r3_r3", mk(8'h08, 8'h08, 0, 0, 0, 0, 0, 1, 1));
                step();

                pif.din = 16'h0092; pif.run = 1'b1;
                step();
                pif.run = 1'b0;
                lit("add_r2_r2_t1", mk(8'h00, 8'h04, 1, 0, 0, 0, 0, 0, 1));
                step();
                lit("add_r2_r2_t2", mk(8'h00, 8'h04, 0, 1, 0, 0, 0, 0, 1));
                repeat (2) step();

                repeat (4000) begin
                    pif.run = 1'($urandom_range(0, 1));
                    pif.din = 16'($urandom);
                    step();
                end
                pif.run = 1'b0;
                repeat (4) step();
                lit("final_idle", '0);
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/proc_control.md
Name: proc_control

Overview:
- Instruction-sequencing FSM for the simple CPU datapath.
- Latches a 9-bit instruction from the data input and drives the per-cycle control strobes:
  - register-file in/out enables
  - ALU operand-A load, G load and add/sub select
  - G-to-bus and DIN-to-bus enables
- Guarantees at most one bus driver per cycle and signals completion with done.
- Sits between the instruction source (memory/testbench) and the register file, ALU and bus mux.

Parameters:
DATA_W, 16, width of din; instruction is taken from din[8:0], upper bits ignored.

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
run  in  1  start request; sampled only in state T0
din  in  DATA_W  instruction word (T0) / immediate (T1 of mvi, consumed by datapath)
rin  out  8  one-hot register load enables R0..R7
rout  out  8  one-hot register bus-drive enables R0..R7
ain  out  1  load ALU operand register A from bus
gin  out  1  load ALU result register G
sub  out  1  ALU op select: 0 add, 1 subtract
gout  out  1  G drives bus
dinout  out  1  din drives bus
done  out  1  instruction complete (high in final cycle)
busy  out  1  high in any state other than T0

Behaviour:
- Instruction format IR[8:0] = III XXX YYY. Opcode III; X = destination/first operand reg; Y = source reg.
  - 000 mv Rx,Ry
  - 001 mvi Rx,#din
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 1xx undefined (no-op)
- States: T0 (idle/fetch), T1, T2, T3. Two-bit state register plus 9-bit IR, both async-cleared by resetn low. Reset values: state=T0, IR=0.
- All outputs are combinational decodes of (state, IR). In T0 every output is 0.
- T0:
  - run=1 at a rising edge: IR <= din[8:0], next=T1.
  - run=0: stay T0, IR holds.
- T1:
  - mv: rout[Y]=1, rin[X]=1, done=1, next T0.
  - mvi: dinout=1, rin[X]=1, done=1, next T0.
  - add/sub: rout[X]=1, ain=1, next T2.
  - undefined: done=1 only, next T0.
- T2 (add/sub): rout[Y]=1, gin=1, sub=IR[6] (0 add, 1 sub), next T3.
- T3 (add/sub): gout=1, rin[X]=1, done=1, next T0.
- sub is 0 in every cycle except T2 of sub. This makes the ALU default to add.
- Latency, counted from the edge that samples run:
  - mv/mvi/undefined: done in the following cycle (2 cycles incl. T0).
  - add/sub: done 3 cycles later (4 incl. T0).
- Back-to-back: after done, the FSM spends at least one cycle in T0 before the next fetch.
- run while busy=1: ignored, no queuing. A new instruction is accepted only on an edge in T0.
- Bus-driver invariant: popcount(rout)+gout+dinout <= 1 in every cycle.
- rin is one-hot or zero. ain and gin are never high together.
- X==Y is legal:
  - mv R3,R3: rout[3] and rin[3] both high.
  - add R2,R2 doubles R2 (A=R2 at T1, bus=R2 at T2).
- resetn low at any time: state->T0 and IR->0 immediately, all outputs 0 without waiting for clock. The interrupted instruction is abandoned, with no partial rin write after reset. The first accepted instruction after release is on the first rising edge with resetn=1 and run=1.

Test Plan:
- Reset with run=1, din=0x049 → all outputs 0 while resetn=0. Release → next edge loads IR=0x049 (mvi R1). T1 shows dinout=1, rin=0x02, done=1, busy=1; then T0.
- mv R5,R2 (din=0x02A), run pulse → T1: rout=0x04, rin=0x20, done=1; no other strobe high.
- add R0,R1 (din=0x081) → T1: rout=0x01, ain=1. T2: rout=0x02, gin=1, sub=0. T3: gout=1, rin=0x01, done=1. busy low the cycle after.
- sub R3,R4 (din=0x0DC), run held high throughout → T2 sub=1. The run held during T1–T3 is ignored. A second fetch occurs only on the T0 edge after done.
- resetn asserted during T2 of add → outputs 0 immediately, state T0, no rin pulse. After release with run=0 the FSM stays idle.
- Undefined opcode din=0x1FF → T1: done=1, all other strobes 0. Check the bus-driver and one-hot assertions over a random run of 1000 instructions.
